// File: rtl/fetch_scheduler_pkg.sv
// Shared definitions for the fetch scheduler: command layout, fetch type codes
// and scheduler FSM states.
package fetch_scheduler_pkg;

  localparam int TYPE_W = 8;
  localparam int SRC_W  = 16;
  localparam int DST_W  = 8;
  localparam int SEL_W  = 8;
  localparam int CNT_W  = 8;
  localparam int CMD_W  = TYPE_W + SRC_W + DST_W + SEL_W + CNT_W;

  localparam logic [TYPE_W-1:0] FETCH_TYPE_FEATURE = 8'h01;
  localparam logic [TYPE_W-1:0] FETCH_TYPE_WEIGHT  = 8'h02;
  localparam logic [TYPE_W-1:0] FETCH_TYPE_SCALER  = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } sched_state_e;

  // Field order matches the 48-bit FIFO entry {type,src,dst,mem_sel,counter}.
  typedef struct packed {
    logic [TYPE_W-1:0] fetch_type;
    logic [SRC_W-1:0]  src_addr;
    logic [DST_W-1:0]  dst_addr;
    logic [SEL_W-1:0]  mem_sel;
    logic [CNT_W-1:0]  counter;
  } fetch_cmd_t;

  function automatic logic is_legal_type(input logic [TYPE_W-1:0] t);
    return (t == FETCH_TYPE_FEATURE) || (t == FETCH_TYPE_WEIGHT) || (t == FETCH_TYPE_SCALER);
  endfunction

endpackage

// File: rtl/fetch_scheduler_cmd_fifo.sv
// Show-ahead synchronous command FIFO: head is valid whenever empty is low,
// pop simply advances it. DEPTH must be a power of two.
module fetch_cmd_fifo
  import fetch_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_cmd_t             push_data,
  input  logic                   pop,
  output fetch_cmd_t             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  fetch_cmd_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: the storage array is deliberately left out of reset; only the
  // pointers and count define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == LW'(DEPTH));
  assign level = count;

endmodule

// File: rtl/fetch_scheduler.sv
// Queues fetch commands and issues them one at a time to the feature or
// weight/scaler fetch unit, holding each until its unit reports done.
// Optional WAIT watchdog is built when FETCH_TIMEOUT_EN is defined.
module fetch_scheduler
  import fetch_scheduler_pkg::*;
#(
  parameter int QUEUE_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [TYPE_W-1:0]            cmd_type,
  input  logic [SRC_W-1:0]             cmd_src_addr,
  input  logic [DST_W-1:0]             cmd_dst_addr,
  input  logic [SEL_W-1:0]             cmd_mem_sel,
  input  logic [CNT_W-1:0]             cmd_counter,
  output logic                         feature_fetch_enable,
  output logic                         weight_fetch_enable,
  output logic                         scaler_fetch_enable,
  output logic [TYPE_W-1:0]            fetch_type,
  output logic [SRC_W-1:0]             fetch_src_addr,
  output logic [DST_W-1:0]             fetch_dst_addr,
  output logic [SEL_W-1:0]             fetch_mem_sel,
  output logic [CNT_W-1:0]             fetch_counter,
  input  logic                         feature_fetch_done,
  input  logic                         weight_fetch_done,
  output logic [$clog2(QUEUE_DEPTH):0] queue_level,
  output logic                         sched_idle,
  output logic                         err_illegal,
  output logic                         stray_done,
  output logic                         timeout_err
);

  sched_state_e state;
  sched_state_e state_nxt;
  fetch_cmd_t   push_cmd;
  fetch_cmd_t   head;
  fetch_cmd_t   op_q;
  logic         fifo_full;
  logic         fifo_empty;
  logic         pop;
  logic         issue;
  logic         illegal_hit;
  logic         timeout_hit;
  logic         await_feature;
  logic         await_weight;
  logic         done_match;
  logic         stray_hit;
  logic         wd_expired;

  assign cmd_ready = !fifo_full;
  assign push_cmd  = '{fetch_type: cmd_type, src_addr: cmd_src_addr, dst_addr: cmd_dst_addr,
                       mem_sel: cmd_mem_sel, counter: cmd_counter};

  fetch_cmd_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid && cmd_ready),
    .push_data (push_cmd),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (queue_level)
  );

  // In WAIT the bus always holds a legal type, so scaler falls to the weight unit.
  assign await_feature = (state == ST_WAIT) && (op_q.fetch_type == FETCH_TYPE_FEATURE);
  assign await_weight  = (state == ST_WAIT) && (op_q.fetch_type != FETCH_TYPE_FEATURE);
  assign done_match    = (feature_fetch_done && await_feature) || (weight_fetch_done && await_weight);
  assign stray_hit     = (feature_fetch_done && !await_feature) || (weight_fetch_done && !await_weight);

`ifdef FETCH_TIMEOUT_EN
  logic [15:0] wd_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_count <= '0;
    end else if (state == ST_ISSUE) begin
      wd_count <= '0;
    end else if (state == ST_WAIT) begin
      wd_count <= wd_count + 16'd1;
    end
  end

  assign wd_expired = (state == ST_WAIT) && (wd_count == 16'(TIMEOUT_CYCLES - 1));
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path through the block leaves a variable unassigned (no latches).
  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    issue       = 1'b0;
    illegal_hit = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (is_legal_type(head.fetch_type)) begin
            state_nxt = ST_ISSUE;
          end else begin
            illegal_hit = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        issue     = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_match) begin
          state_nxt = ST_IDLE;
        end else if (wd_expired) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand bus is captured on every pop and then held; units sample it only
  // while their enable is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q                 <= '0;
      feature_fetch_enable <= 1'b0;
      weight_fetch_enable  <= 1'b0;
      scaler_fetch_enable  <= 1'b0;
      err_illegal          <= 1'b0;
      stray_done           <= 1'b0;
      timeout_err          <= 1'b0;
      sched_idle           <= 1'b1;
    end else begin
      if (pop) op_q <= head;
      feature_fetch_enable <= issue && (op_q.fetch_type == FETCH_TYPE_FEATURE);
      weight_fetch_enable  <= issue && (op_q.fetch_type == FETCH_TYPE_WEIGHT);
      scaler_fetch_enable  <= issue && (op_q.fetch_type == FETCH_TYPE_SCALER);
      err_illegal          <= illegal_hit;
      stray_done           <= stray_hit;
      timeout_err          <= timeout_hit;
      sched_idle           <= (state == ST_IDLE) && fifo_empty;
    end
  end

  assign fetch_type     = op_q.fetch_type;
  assign fetch_src_addr = op_q.src_addr;
  assign fetch_dst_addr = op_q.dst_addr;
  assign fetch_mem_sel  = op_q.mem_sel;
  assign fetch_counter  = op_q.counter;

endmodule
